gmii_tx_frame_arbiter: RTL and testbench
========================================

// Module: gmii_tx_frame_arbiter
// PURPOSE
//  Shares the single GMII TX port between NUM_REQ byte-stream requesters (e.g. ARP, UDP) with round-robin arbitration.
//  Frames each granted packet with preamble and SFD, enforces the inter-frame gap, and aborts on source underrun.
//  Drives gmii_tx_en/er/data directly into the GMII-to-RGMII DDR output stage, in the gmii_tx_clk domain.
// PARAMETERS
//  NUM_REQ       2   number of requesters (2..8)
//  PREAMBLE_LEN  7   count of 0x55 preamble bytes before SFD (1..15)
//  IFG_LEN       12  minimum tx_en-low cycles between frames (2..255)
// PORTS
//  gmii_tx_clk   in   1          125 MHz TX clock; all logic on rising edge
//  sys_rst       in   1          asynchronous, active-high reset
//  tx_enable     in   1          1 = new grants allowed; a frame in flight always completes
//  s_valid       in   NUM_REQ    per-requester byte valid; held until accepted
//  s_data        in   NUM_REQ*8  per-requester byte, requester i at [8i+7:8i]
//  s_last        in   NUM_REQ    final byte of the frame
//  s_ready       out  NUM_REQ    byte accepted when s_valid&s_ready (combinational from state/grant)
//  gmii_tx_en    out  1          registered GMII enable
//  gmii_tx_er    out  1          registered GMII error
//  gmii_tx_data  out  8          registered GMII data
//  busy          out  1          state != IDLE
//  grant_id      out  clog2(NUM_REQ)  index of current/last granted requester
//  frame_done    out  1          1-cycle pulse with the last data byte on gmii_tx_data
//  underrun      out  1          1-cycle pulse with the tx_er error byte
//  frame_cnt     out  16         frames completed OK; wraps 0xFFFF->0x0000; aborted frames not counted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; s_ready 0; round-robin pointer so requester 0 has highest priority.
//  States: IDLE, PRE, SFD, DATA, DROP, IFG.
//  IDLE: if tx_enable & |s_valid, grant first valid requester searching from (last_grant+1) mod NUM_REQ
//    upward with wrap; latch grant_id; next edge -> PRE, gmii_tx_en<=1, data<=0x55.
//  Requests are sampled only in IDLE; a request rising mid-frame waits. s_ready=0 in IDLE/PRE/SFD/IFG.
//  PRE: emits 0x55 for PREAMBLE_LEN cycles total, then SFD emits 0xD5 for one cycle.
//  DATA: s_ready[grant]=1. Valid beat -> next edge gmii_tx_data<=byte, tx_en=1, tx_er=0.
//    Beat with s_last -> last byte out, frame_done pulse, frame_cnt+1, -> IFG.
//  Underrun (DATA, s_valid[grant]=0): next edge outputs tx_en=1, tx_er=1, data=0x00 for one cycle,
//    underrun pulse, -> DROP. The frame is not retried.
//  DROP: tx_en=0; s_ready[grant]=1; bytes discarded until valid&last; then -> IFG.
//  IFG: tx_en=0, er=0, data=0x00 for IFG_LEN-1 cycles, then IDLE. The IDLE cycle is the final gap cycle,
//    so back-to-back frames show exactly IFG_LEN tx_en-low cycles.
//  Latency: first byte after SFD appears 1 cycle after its handshake; SFD immediately precedes data byte 0.
//  tx_enable low: no new grant in IDLE; frames in PRE/SFD/DATA/DROP/IFG finish normally.
//  NUM_REQ=1: grant always 0; rotation is degenerate.
//  Reset asserted mid-frame: immediate return to reset values; the frame is truncated on the wire
//    (tx_en drops, no tx_er); frame_cnt cleared.
//  Counters: preamble counter 4 bits; IFG counter 8 bits; no overflow within legal parameters.
// TESTING
//  1 req0 frame {0x11,0x22,0x33}, tx_enable=1 -> tx_en high 11 cycles:
//    7x55, D5, 11, 22, 33; frame_done with 0x33; frame_cnt=1; then tx_en low >=12.
//  2 req0 and req1 both valid continuously, 2-byte frames -> grants 0,1,0,1; gaps exactly 12 low cycles;
//    frame_cnt=4 after 4 frames.
//  3 req1 drops s_valid after 1 data byte of 4 -> one cycle en=1/er=1/data=00; underrun pulse;
//    remaining 3 bytes dropped with s_ready=1, en=0; frame_cnt unchanged; IFG follows.
//  4 sys_rst pulsed during 3rd preamble byte -> outputs 0 asynchronously; after release, pending req0
//    restarts with a full 7-byte preamble.
//  5 tx_enable=0 with req0 valid -> no tx_en for 50 cycles; tx_enable=1 -> preamble begins next cycle.
//  6 frame_cnt preset by forcing 0xFFFF, one good frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/gmii_tx_frame_arbiter.sv
// Shares one GMII TX port between NUM_REQ byte-stream requesters with round-robin grants.
// Each frame gets preamble + SFD, an underrun aborts it with tx_er, and the inter-frame gap is enforced.
module gmii_tx_frame_arbiter #(
   parameter int  NUM_REQ      = 2,
   parameter int  PREAMBLE_LEN = 7,
   parameter int  IFG_LEN      = 12,
   localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 gmii_tx_clk,
   input  logic                 sys_rst,
   input  logic                 tx_enable,
   input  logic [NUM_REQ-1:0]   s_valid,
   input  logic [NUM_REQ*8-1:0] s_data,
   input  logic [NUM_REQ-1:0]   s_last,
   output logic [NUM_REQ-1:0]   s_ready,
   output logic                 gmii_tx_en,
   output logic                 gmii_tx_er,
   output logic [7:0]           gmii_tx_data,
   output logic                 busy,
   output logic [GW-1:0]        grant_id,
   output logic                 frame_done,
   output logic                 underrun,
   output logic [15:0]          frame_cnt
);
   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DROP, IFG} state_t;

   state_t               state, state_nxt;
   logic [3:0]           pre_cnt;
   logic [7:0]           ifg_cnt;
   logic [GW-1:0]        last_grant, start, pick;
   logic [2*NUM_REQ-1:0] rot;
   logic                 found, grant_go;
   logic                 cur_valid, cur_last;
   logic [7:0]           cur_data;
   logic                 en_nxt, er_nxt, done_nxt, under_nxt;
   logic [7:0]           data_nxt;

   // Rotate the request vector so the search starts just after the last grant.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      start = (last_grant == GW'(NUM_REQ - 1)) ? '0 : last_grant + GW'(1);
      rot   = {s_valid, s_valid} >> start;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            pick  = GW'((int'(start) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_id == GW'(k)) begin
            cur_valid = s_valid[k];
            cur_last  = s_last[k];
            cur_data  = s_data[8*k +: 8];
         end
      end
   end

   assign grant_go = (state == IDLE) && tx_enable && found;
   assign busy     = (state != IDLE);

   // NOTE: all flops use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // SFD is the cycle holding the last preamble byte; DATA starts while 0xD5 is on the wire.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (grant_go) state_nxt = (PREAMBLE_LEN == 1) ? SFD : PRE;
         PRE:  if (pre_cnt == 4'(PREAMBLE_LEN - 1)) state_nxt = SFD;
         SFD:  state_nxt = DATA;
         DATA: begin
            if (!cur_valid)    state_nxt = DROP;
            else if (cur_last) state_nxt = IFG;
         end
         DROP: if (cur_valid && cur_last) state_nxt = IFG;
         IFG:  if (ifg_cnt == 8'(IFG_LEN - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      en_nxt    = 1'b0;
      er_nxt    = 1'b0;
      data_nxt  = 8'h00;
      done_nxt  = 1'b0;
      under_nxt = 1'b0;
      s_ready   = '0;
      case (state)
         IDLE: if (grant_go) begin
            en_nxt   = 1'b1;
            data_nxt = 8'h55;
         end
         PRE: begin
            en_nxt   = 1'b1;
            data_nxt = 8'h55;
         end
         SFD: begin
            en_nxt   = 1'b1;
            data_nxt = 8'hD5;
         end
         DATA: begin
            s_ready[grant_id] = 1'b1;
            en_nxt            = 1'b1;
            if (cur_valid) begin
               data_nxt = cur_data;
               done_nxt = cur_last;
            end else begin
               er_nxt    = 1'b1;
               under_nxt = 1'b1;
            end
         end
         DROP: s_ready[grant_id] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gmii_tx_en   <= 1'b0;
         gmii_tx_er   <= 1'b0;
         gmii_tx_data <= 8'h00;
         frame_done   <= 1'b0;
         underrun     <= 1'b0;
         frame_cnt    <= 16'h0000;
         grant_id     <= '0;
         last_grant   <= GW'(NUM_REQ - 1);
         pre_cnt      <= 4'd0;
         ifg_cnt      <= 8'd0;
      end else begin
         gmii_tx_en   <= en_nxt;
         gmii_tx_er   <= er_nxt;
         gmii_tx_data <= data_nxt;
         frame_done   <= done_nxt;
         underrun     <= under_nxt;
         if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
         if (grant_go) begin
            grant_id   <= pick;
            last_grant <= pick;
         end
         // pre_cnt counts preamble bytes already launched, including the one from the grant edge.
         if (grant_go)          pre_cnt <= 4'd1;
         else if (state == PRE) pre_cnt <= pre_cnt + 4'd1;
         ifg_cnt <= (state == IFG) ? ifg_cnt + 8'd1 : 8'd0;
      end
   end
endmodule

// File: tb/tb_gmii_tx_frame_arbiter.sv
// Bench for gmii_tx_frame_arbiter: a frame-level model checked every cycle,
// plus directed scenarios with hand-computed wire contents.
module tb_gmii_tx_frame_arbiter;
   localparam int NUM_REQ = 2;
   localparam int PRE     = 7;
   localparam int IFG     = 12;
   localparam int SAT     = 1000;

   typedef struct {
      logic [7:0] data;
      bit         last;
      int         dly;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_enable = 1'b0;
   logic [1:0]  s_valid = '0;
   logic [15:0] s_data = '0;
   logic [1:0]  s_last = '0;
   logic [1:0]  s_ready;
   logic        gmii_tx_en, gmii_tx_er;
   logic [7:0]  gmii_tx_data;
   logic        busy;
   logic [0:0]  grant_id;
   logic        frame_done, underrun;
   logic [15:0] frame_cnt;

   gmii_tx_frame_arbiter #(.NUM_REQ(NUM_REQ), .PREAMBLE_LEN(PRE), .IFG_LEN(IFG)) dut (
      .gmii_tx_clk (clk),
      .sys_rst     (rst),
      .tx_enable   (tx_enable),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_tx_er  (gmii_tx_er),
      .gmii_tx_data(gmii_tx_data),
      .busy        (busy),
      .grant_id    (grant_id),
      .frame_done  (frame_done),
      .underrun    (underrun),
      .frame_cnt   (frame_cnt)
   );

   always #4 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- source drivers ----------------
   beat_t      beats[2][64];
   int         head[2] = '{0, 0};
   int         tail[2] = '{0, 0};
   int         dly[2]  = '{0, 0};
   bit         loaded[2] = '{0, 0};
   logic [1:0] rdy_prev = '0;

   task automatic push(input int r, input logic [7:0] d, input bit l, input int dl);
      beats[r][tail[r]] = '{d, l, dl};
      tail[r]++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int r = 0; r < 2; r++) begin
            if (s_valid[r] && rdy_prev[r] && !rst) begin
               head[r]++;
               loaded[r] = 0;
            end
            if (head[r] < tail[r]) begin
               if (!loaded[r]) begin
                  dly[r]    = beats[r][head[r]].dly;
                  loaded[r] = 1;
               end
               if (dly[r] > 0) begin
                  dly[r]--;
                  s_valid[r] = 1'b0;
               end else begin
                  s_valid[r]       = 1'b1;
                  s_data[r*8 +: 8] = beats[r][head[r]].data;
                  s_last[r]        = beats[r][head[r]].last;
               end
            end else begin
               s_valid[r] = 1'b0;
               s_last[r]  = 1'b0;
            end
         end
         rdy_prev = s_ready;
      end
   end

   // ---------------- frame-level model ----------------
   // A frame occupies the wire from its grant edge; the next grant may come no earlier
   // than IFG+1 edges after the edge that ended the previous frame.
   logic        exp_en, exp_er, exp_done, exp_under;
   logic [7:0]  exp_data;
   logic [0:0]  exp_grant;
   logic [15:0] m_good, m_base = 16'h0000;
   bit          m_on, m_drop;
   int          m_pos, m_since, m_g, m_next;

   task automatic m_reset();
      m_on = 0; m_drop = 0; m_pos = 0; m_since = SAT; m_g = 0; m_next = 0;
      m_good = 16'h0000;
      exp_en = 0; exp_er = 0; exp_data = 8'h00; exp_done = 0; exp_under = 0; exp_grant = 1'b0;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_reset();
         end else begin
            exp_en = 0; exp_er = 0; exp_data = 8'h00; exp_done = 0; exp_under = 0;
            if (!m_on) begin
               if (m_since < SAT) m_since++;
               if (m_since > IFG && tx_enable && s_valid != 2'b00) begin
                  for (int k = NUM_REQ - 1; k >= 0; k--)
                     if (s_valid[(m_next + k) % NUM_REQ]) m_g = (m_next + k) % NUM_REQ;
                  m_next    = (m_g + 1) % NUM_REQ;
                  exp_grant = 1'(m_g);
                  m_on = 1; m_drop = 0; m_pos = 1;
                  exp_en = 1; exp_data = 8'h55;
               end
            end else if (m_drop) begin
               if (s_valid[m_g] && s_last[m_g]) begin
                  m_on = 0; m_since = 0;
               end
            end else if (m_pos <= PRE) begin
               exp_en   = 1;
               exp_data = (m_pos < PRE) ? 8'h55 : 8'hD5;
               m_pos++;
            end else if (s_valid[m_g]) begin
               exp_en   = 1;
               exp_data = s_data[m_g*8 +: 8];
               if (s_last[m_g]) begin
                  exp_done = 1;
                  m_good   = m_good + 16'd1;
                  m_on = 0; m_since = 0;
               end
            end else begin
               exp_en = 1; exp_er = 1; exp_under = 1;
               m_drop = 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare + wire recorder ----------------
   int         nfr = 0;
   int         fr_len[16];
   int         fr_gap[16];
   int         fr_grant[16];
   int         fr_err[16];
   logic [7:0] fr_byte[16][32];
   int         low_run = 0;
   int         n_under = 0;
   logic       prev_en = 1'b0;
   logic [7:0] done_byte = 8'h00;

   initial begin
      logic [1:0] exp_ready;
      logic       exp_busy;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_en = 1'b0;
            low_run = 0;
         end else begin
            exp_ready = (m_on && (m_drop || m_pos == PRE + 1)) ? 2'(1 << m_g) : 2'b00;
            exp_busy  = m_on || (m_since < IFG);
            check("wire", {gmii_tx_en, gmii_tx_er, gmii_tx_data}, {exp_en, exp_er, exp_data});
            check("pulses", {frame_done, underrun}, {exp_done, exp_under});
            check("busy", busy, exp_busy);
            check("grant_id", grant_id, exp_grant);
            check("s_ready", s_ready, exp_ready);
            check("frame_cnt", frame_cnt, 16'(m_base + m_good));
            if (gmii_tx_en && !prev_en && nfr < 16) begin
               fr_gap[nfr] = low_run; fr_grant[nfr] = int'(grant_id);
               fr_len[nfr] = 0;       fr_err[nfr]   = 0;
               nfr++;
            end
            if (gmii_tx_en) begin
               if (nfr > 0) begin
                  if (fr_len[nfr-1] < 32) fr_byte[nfr-1][fr_len[nfr-1]] = gmii_tx_data;
                  fr_len[nfr-1]++;
                  if (gmii_tx_er) fr_err[nfr-1]++;
               end
               low_run = 0;
            end else begin
               low_run++;
            end
            if (underrun)   n_under++;
            if (frame_done) done_byte = gmii_tx_data;
            prev_en = gmii_tx_en;
         end
      end
   end

   function automatic logic [127:0] fbytes(input int f, input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n; i++) v = {v[119:0], fr_byte[f][i]};
      return v;
   endfunction

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || head[0] < tail[0] || head[1] < tail[1]) && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, n < 2000, 1'b1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("reset tx_en", gmii_tx_en, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset frame_cnt", frame_cnt, 16'h0000);
      check("reset s_ready", s_ready, 2'b00);
      rst = 1'b0;
      tx_enable = 1'b1;

      // 1: single req0 frame
      @(posedge clk); #1;
      push(0, 8'h11, 0, 0); push(0, 8'h22, 0, 0); push(0, 8'h33, 1, 0);
      wait_idle("t1 timeout");
      check("t1 frames", nfr, 1);
      check("t1 len", fr_len[0], 11);
      check("t1 bytes", fbytes(0, 11), 128'h55555555555555D5112233);
      check("t1 done byte", done_byte, 8'h33);
      check("t1 frame_cnt", frame_cnt, 16'd1);

      // 2: both requesters, back-to-back 2-byte frames, from a fresh reset
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      push(0, 8'hA0, 0, 0); push(0, 8'hA1, 1, 0); push(0, 8'hA2, 0, 0); push(0, 8'hA3, 1, 0);
      push(1, 8'hB0, 0, 0); push(1, 8'hB1, 1, 0); push(1, 8'hB2, 0, 0); push(1, 8'hB3, 1, 0);
      wait_idle("t2 timeout");
      check("t2 frames", nfr, 5);
      check("t2 grants", {fr_grant[1][0], fr_grant[2][0], fr_grant[3][0], fr_grant[4][0]}, 4'b0101);
      for (int k = 2; k <= 4; k++) check("t2 gap", fr_gap[k], 12);
      check("t2 req1 bytes", fbytes(2, 10), 128'h55555555555555D5B0B1);
      check("t2 frame_cnt", frame_cnt, 16'd4);

      // 3: req1 underrun after first data byte
      @(posedge clk); #1;
      push(1, 8'hC0, 0, 0); push(1, 8'hC1, 0, 1); push(1, 8'hC2, 0, 0); push(1, 8'hC3, 1, 0);
      wait_idle("t3 timeout");
      check("t3 frames", nfr, 6);
      check("t3 grant", fr_grant[5], 1);
      check("t3 len", fr_len[5], 10);
      check("t3 bytes", fbytes(5, 10), 128'h55555555555555D5C000);
      check("t3 er cycles", fr_err[5], 1);
      check("t3 underrun pulses", n_under, 1);
      check("t3 frame_cnt", frame_cnt, 16'd4);

      // 4: reset during the third preamble byte
      @(posedge clk); #1;
      push(0, 8'h44, 0, 0); push(0, 8'h45, 1, 0);
      n = 0;
      while (!(nfr == 7 && fr_len[6] == 3) && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("t4 preamble reached", n < 100, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("t4 async tx_en", gmii_tx_en, 1'b0);
      check("t4 async data", gmii_tx_data, 8'h00);
      check("t4 async busy", busy, 1'b0);
      check("t4 async frame_cnt", frame_cnt, 16'h0000);
      @(negedge clk); #1;
      rst = 1'b0;
      wait_idle("t4 timeout");
      check("t4 frames", nfr, 8);
      check("t4 restart bytes", fbytes(7, 10), 128'h55555555555555D54445);
      check("t4 frame_cnt", frame_cnt, 16'd1);

      // 5: tx_enable low holds off a pending request
      tx_enable = 1'b0;
      @(posedge clk); #1;
      push(0, 8'h66, 1, 0);
      repeat (50) @(negedge clk);
      #1;
      check("t5 no frame", nfr, 8);
      check("t5 idle", busy, 1'b0);
      tx_enable = 1'b1;
      @(negedge clk); #1;
      check("t5 start", {gmii_tx_en, gmii_tx_data}, {1'b1, 8'h55});
      wait_idle("t5 timeout");
      check("t5 frame_cnt", frame_cnt, 16'd2);

      // 6: frame counter wrap
      force dut.frame_cnt = 16'hFFFF;
      m_base = 16'hFFFF - m_good;
      #1 release dut.frame_cnt;
      @(negedge clk); #1;
      check("t6 preset held", frame_cnt, 16'hFFFF);
      @(posedge clk); #1;
      push(0, 8'h77, 0, 0); push(0, 8'h78, 1, 0);
      wait_idle("t6 timeout");
      check("t6 bytes", fbytes(9, 10), 128'h55555555555555D57778);
      check("t6 wrap", frame_cnt, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
